// File: rtl/ise_pkg.sv
// Shared types and default sizes for the ISE image-sorting engine control path.
package ise_pkg;

  localparam int DEF_IMAGE_NUM = 32;
  localparam int DEF_IMG_PIX   = 16384;
  localparam int DEF_SCORE_W   = 22;
  localparam int DEF_IDX_W     = 5;

  typedef logic [1:0] color_t;
  localparam color_t COL_R = 2'd0;
  localparam color_t COL_G = 2'd1;
  localparam color_t COL_B = 2'd2;

  typedef struct packed {
    color_t                 color;
    logic [DEF_SCORE_W-1:0] score;
    logic [DEF_IDX_W-1:0]   idx;
  } entry_t;

  typedef logic [2:0] state_t;
  localparam state_t INGEST   = 3'd0;
  localparam state_t WAIT_RES = 3'd1;
  localparam state_t SCAN     = 3'd2;
  localparam state_t EMIT     = 3'd3;
  localparam state_t DONE     = 3'd4;

endpackage

// File: rtl/ise_entry_cmp.sv
// Stateless ordering test: colour ascending, then score descending, then index ascending.
module ise_entry_cmp
  import ise_pkg::*;
#(
  parameter int SCORE_W = DEF_SCORE_W,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  color_t             a_color_i,
  input  logic [SCORE_W-1:0] a_score_i,
  input  logic [IDX_W-1:0]   a_idx_i,
  input  color_t             b_color_i,
  input  logic [SCORE_W-1:0] b_score_i,
  input  logic [IDX_W-1:0]   b_idx_i,
  output logic               beats_o
);

  logic same_color;
  logic same_score;

  assign same_color = (a_color_i == b_color_i);
  assign same_score = (a_score_i == b_score_i);

  assign beats_o = (a_color_i < b_color_i)
                || (same_color && (a_score_i > b_score_i))
                || (same_color && same_score && (a_idx_i < b_idx_i));

endmodule

// File: rtl/ise_sort_scheduler.sv
// Frames incoming images for the accumulator, collects one result per image,
// then selection-sorts the table and streams it out one entry per scan pass.
module ise_sort_scheduler
  import ise_pkg::*;
#(
  parameter int IMAGE_NUM = DEF_IMAGE_NUM,
  parameter int IMG_PIX   = DEF_IMG_PIX,
  parameter int SCORE_W   = DEF_SCORE_W,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic [IDX_W-1:0]   pix_index,
  output logic               acc_start,
  output logic               acc_last,
  input  logic               res_valid,
  input  color_t             res_color,
  input  logic [SCORE_W-1:0] res_score,
  output logic               busy,
  output logic               out_valid,
  output color_t             color_index,
  output logic [IDX_W-1:0]   image_out_index,
  output logic               done
);

  localparam int PTR_W = (IMAGE_NUM > 1) ? $clog2(IMAGE_NUM) : 1;
  localparam int PIX_W = (IMG_PIX > 1) ? $clog2(IMG_PIX) : 1;
  localparam logic [PTR_W-1:0] LAST_IMG = PTR_W'(IMAGE_NUM - 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(IMG_PIX - 1);

  typedef struct packed {
    color_t             color;
    logic [SCORE_W-1:0] score;
    logic [IDX_W-1:0]   idx;
  } slot_t;

  state_t               state_q, state_d;
  logic [PIX_W-1:0]     pix_cnt_q, pix_cnt_d;
  logic [IDX_W-1:0]     cur_idx_q, cur_idx_d;
  logic [PTR_W-1:0]     img_cnt_q, img_cnt_d;
  logic [PTR_W-1:0]     scan_ptr_q, scan_ptr_d;
  logic [PTR_W-1:0]     emit_cnt_q, emit_cnt_d;
  logic [PTR_W-1:0]     best_ptr_q, best_ptr_d;
  logic [IMAGE_NUM-1:0] used_q, used_d;
  slot_t                best_q, best_d;
  logic                 best_vld_q, best_vld_d;
  logic                 out_valid_q;
  color_t               color_q;
  logic [IDX_W-1:0]     img_out_q;

  slot_t                tbl_q [IMAGE_NUM];
  slot_t                cand;
  logic                 cand_beats;
  logic                 tbl_we;
  logic                 accept;

  // Gated by reset so a pixel held during reset never raises acc_start.
  assign accept    = pix_valid && reset && (state_q == INGEST);
  assign acc_start = accept && (pix_cnt_q == '0);
  assign acc_last  = accept && (pix_cnt_q == LAST_PIX);
  assign cand      = tbl_q[scan_ptr_q];

  ise_entry_cmp #(
    .SCORE_W (SCORE_W),
    .IDX_W   (IDX_W)
  ) u_cmp (
    .a_color_i (cand.color),
    .a_score_i (cand.score),
    .a_idx_i   (cand.idx),
    .b_color_i (best_q.color),
    .b_score_i (best_q.score),
    .b_idx_i   (best_q.idx),
    .beats_o   (cand_beats)
  );

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    cur_idx_d  = cur_idx_q;
    img_cnt_d  = img_cnt_q;
    scan_ptr_d = scan_ptr_q;
    emit_cnt_d = emit_cnt_q;
    best_ptr_d = best_ptr_q;
    used_d     = used_q;
    best_d     = best_q;
    best_vld_d = best_vld_q;
    tbl_we     = 1'b0;
    case (state_q)
      INGEST: begin
        if (accept) begin
          if (pix_cnt_q == '0) cur_idx_d = pix_index;
          if (pix_cnt_q == LAST_PIX) begin
            pix_cnt_d = '0;
            state_d   = WAIT_RES;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      WAIT_RES: begin
        if (res_valid) begin
          tbl_we            = 1'b1;
          used_d[img_cnt_q] = 1'b0;
          if (img_cnt_q == LAST_IMG) begin
            img_cnt_d  = '0;
            scan_ptr_d = '0;
            best_vld_d = 1'b0;
            state_d    = SCAN;
          end else begin
            img_cnt_d = img_cnt_q + 1'b1;
            state_d   = INGEST;
          end
        end
      end
      SCAN: begin
        if (!used_q[scan_ptr_q] && (!best_vld_q || cand_beats)) begin
          best_d     = cand;
          best_ptr_d = scan_ptr_q;
          best_vld_d = 1'b1;
        end
        if (scan_ptr_q == LAST_IMG) state_d = EMIT;
        else                        scan_ptr_d = scan_ptr_q + 1'b1;
      end
      EMIT: begin
        used_d[best_ptr_q] = 1'b1;
        emit_cnt_d         = emit_cnt_q + 1'b1;
        if (emit_cnt_q == LAST_IMG) begin
          state_d = DONE;
        end else begin
          state_d    = SCAN;
          scan_ptr_d = '0;
          best_vld_d = 1'b0;
        end
      end
      DONE: begin
        emit_cnt_d = '0;
        img_cnt_d  = '0;
        pix_cnt_d  = '0;
        state_d    = INGEST;
      end
      default: state_d = INGEST;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= INGEST;
      pix_cnt_q   <= '0;
      cur_idx_q   <= '0;
      img_cnt_q   <= '0;
      scan_ptr_q  <= '0;
      emit_cnt_q  <= '0;
      best_ptr_q  <= '0;
      used_q      <= '0;
      best_q      <= '0;
      best_vld_q  <= 1'b0;
      out_valid_q <= 1'b0;
      color_q     <= '0;
      img_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      cur_idx_q   <= cur_idx_d;
      img_cnt_q   <= img_cnt_d;
      scan_ptr_q  <= scan_ptr_d;
      emit_cnt_q  <= emit_cnt_d;
      best_ptr_q  <= best_ptr_d;
      used_q      <= used_d;
      best_q      <= best_d;
      best_vld_q  <= best_vld_d;
      out_valid_q <= (state_d == EMIT);
      // The winner of the final scan step is only in best_d, so load from it.
      if (state_d == EMIT) begin
        color_q   <= best_d.color;
        img_out_q <= best_d.idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) tbl_q[img_cnt_q] <= {res_color, res_score, cur_idx_q};
  end

  assign busy            = (state_q != INGEST);
  assign done            = (state_q == DONE);
  assign out_valid       = out_valid_q;
  assign color_index     = color_q;
  assign image_out_index = img_out_q;

endmodule
